// File: rtl/fp_divider_seq.sv
// fp_divider_seq
//   Sequential IEEE-754 binary floating-point divider, result = a / b.
//   The restoring divider produces one quotient bit per clock. The result is
//   truncated (round toward zero). Denormal inputs are treated as signed zero,
//   and denormal results are never produced.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only while idle
//   a, b         dividend / divisor, captured on the accepting edge
//   result       quotient; held from done until the next accepted start
//   done         one-cycle pulse, result and flags valid
//   busy         high whenever the FSM is not idle
//   overflow     result saturated to +/-Inf
//   underflow    result flushed to +/-0
//   div_by_zero  finite nonzero divided by zero
//
// State    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; operands captured on the accepting edge
// S_UNPACK | classify operands, seed divider and exponent
// S_DIVIDE | one restoring-division step per clock, MANTISSA_WIDTH+2 steps
// S_NORM   | normalise, range check, pack (specials bypass DIVIDE to here)
// S_DONE   | done pulse, then back to idle
module fp_divider_seq #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23,
  localparam int W = 1 + EXP_WIDTH + MANTISSA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         overflow,
  output logic         underflow,
  output logic         div_by_zero
);

  localparam int EW   = EXP_WIDTH;
  localparam int MW   = MANTISSA_WIDTH;
  localparam int XW   = EW + 2;
  localparam int CW   = $clog2(MW + 2);
  localparam int BIAS = 2 ** (EW - 1) - 1;
  localparam logic signed [XW-1:0] EMAX  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;
  localparam logic signed [XW-1:0] EONE  = XW'(1);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t                 r_state;
  logic [W-1:0]           r_a;
  logic [W-1:0]           r_b;
  logic signed [XW-1:0]   r_exp;
  logic [MW+1:0]          r_rem;
  logic [MW:0]            r_div;
  logic [MW+1:0]          r_q;
  logic [CW-1:0]          r_cnt;
  logic                   r_special;
  logic [W-1:0]           r_spec_res;
  logic                   r_spec_dz;

  logic [EW-1:0]          w_ea, w_eb;
  logic [MW-1:0]          w_fa, w_fb;
  logic                   w_sign;
  logic                   w_a_nan, w_a_inf, w_a_zero;
  logic                   w_b_nan, w_b_inf, w_b_zero;
  logic                   w_special, w_spec_dz;
  logic [W-1:0]           w_spec_res;
  logic [W-1:0]           w_inf, w_zero, w_qnan;
  logic signed [XW-1:0]   w_exp0;
  logic                   w_ge;
  logic [MW+1:0]          w_sub;
  logic [MW-1:0]          w_frac;
  logic signed [XW-1:0]   w_exp_n;
  logic                   w_ovf, w_unf;

  assign w_ea   = r_a[W-2:MW];
  assign w_eb   = r_b[W-2:MW];
  assign w_fa   = r_a[MW-1:0];
  assign w_fb   = r_b[MW-1:0];
  assign w_sign = r_a[W-1] ^ r_b[W-1];

  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_a_zero = ~(|w_ea);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_b_zero = ~(|w_eb);

  assign w_inf  = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
  assign w_zero = {w_sign, {(W-1){1'b0}}};
  assign w_qnan = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  always_comb begin
    w_special  = 1'b1;
    w_spec_dz  = 1'b0;
    w_spec_res = w_zero;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = w_qnan;
    end else if (w_a_inf) begin
      w_spec_res = w_inf;
    end else if (w_b_inf || w_a_zero) begin
      w_spec_res = w_zero;
    end else if (w_b_zero) begin
      w_spec_res = w_inf;
      w_spec_dz  = 1'b1;
    end else begin
      w_special  = 1'b0;
    end
  end

  assign w_exp0 = XW'(w_ea) - XW'(w_eb) + XW'(BIAS);

  // Remainder stays below twice the divisor, so the shifted-out MSB is always 0.
  assign w_ge  = (r_rem >= {1'b0, r_div});
  assign w_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

  // Quotient lies in (0.5, 2); an integer bit of 0 means one more left shift.
  assign w_frac  = r_q[MW+1] ? r_q[MW:1] : r_q[MW-1:0];
  assign w_exp_n = r_q[MW+1] ? r_exp : (r_exp - EONE);
  assign w_ovf   = (w_exp_n >= EMAX);
  assign w_unf   = (w_exp_n <= EZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_special   <= 1'b0;
      r_spec_res  <= '0;
      r_spec_dz   <= 1'b0;
      result      <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a         <= a;
            r_b         <= b;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_exp      <= w_exp0;
          r_rem      <= {1'b0, 1'b1, w_fa};
          r_div      <= {1'b1, w_fb};
          r_q        <= '0;
          r_cnt      <= CW'(MW + 1);
          r_special  <= w_special;
          r_spec_res <= w_spec_res;
          r_spec_dz  <= w_spec_dz;
          r_state    <= w_special ? S_NORM : S_DIVIDE;
        end
        S_DIVIDE: begin
          r_rem <= w_sub << 1;
          r_q   <= {r_q[MW:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= S_NORM;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_NORM: begin
          if (r_special) begin
            result      <= r_spec_res;
            div_by_zero <= r_spec_dz;
          end else if (w_ovf) begin
            result   <= w_inf;
            overflow <= 1'b1;
          end else if (w_unf) begin
            result    <= w_zero;
            underflow <= 1'b1;
          end else begin
            result <= {w_sign, w_exp_n[EW-1:0], w_frac};
          end
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
module tb_fp_divider_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         done, busy, overflow, underflow, div_by_zero;

  fp_divider_seq #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .result(result), .done(done), .busy(busy), .overflow(overflow),
    .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        of, uf, dz;
    int          lat;
  } ref_t;

  typedef struct {
    logic [31:0] a, b;
    ref_t        exp;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_prev = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: special-case rules first, then exact integer quotient of the
  // significands truncated to 24 significant bits.
  function automatic ref_t ref_div(input logic [31:0] x, input logic [31:0] y);
    ref_t    r;
    int      ex, ey, e;
    longint  ma, mb, m;
    bit      sg, xn, xi, xz, yn, yi, yz;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sg = x[31] ^ y[31];
    xn = (ex == 255) && (x[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    xz = (ex == 0);
    yn = (ey == 255) && (y[22:0] != 0);
    yi = (ey == 255) && (y[22:0] == 0);
    yz = (ey == 0);
    r.of = 0; r.uf = 0; r.dz = 0; r.lat = 2;
    if (xn || yn || (xz && yz) || (xi && yi)) r.res = 32'h7FC00000;
    else if (xi)      r.res = {sg, 8'hFF, 23'h0};
    else if (yi)      r.res = {sg, 31'h0};
    else if (xz)      r.res = {sg, 31'h0};
    else if (yz)      begin r.res = {sg, 8'hFF, 23'h0}; r.dz = 1; end
    else begin
      r.lat = 27;
      ma = 64'h800000 + longint'(x[22:0]);
      mb = 64'h800000 + longint'(y[22:0]);
      e  = ex - ey + 127;
      if (ma >= mb) m = (ma << 23) / mb;
      else begin
        m = (ma << 24) / mb;
        e = e - 1;
      end
      if (e >= 255)     begin r.res = {sg, 8'hFF, 23'h0}; r.of = 1; end
      else if (e <= 0)  begin r.res = {sg, 31'h0};        r.uf = 1; end
      else              r.res = {sg, e[7:0], m[22:0]};
    end
    return r;
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input ref_t r, input string name);
    int lat;
    bit got;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "/busy_after_accept"}, 64'(busy), 64'd1);
    check({name, "/flags_cleared"}, 64'({overflow, underflow, div_by_zero}), 64'd0);
    check({name, "/result_held"}, 64'(result), 64'(exp_prev));
    lat = 0;
    got = 0;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s/timeout: got no done expected done within 60 edges", name);
    end else begin
      check({name, "/result"}, 64'(result), 64'(r.res));
      check({name, "/flags"}, 64'({overflow, underflow, div_by_zero}), 64'({r.of, r.uf, r.dz}));
      check({name, "/latency"}, 64'(lat), 64'(r.lat));
      exp_prev = r.res;
      @(posedge clk); #1;
      check({name, "/done_one_cycle"}, 64'({done, busy}), 64'd0);
    end
  endtask

  function automatic ref_t mk(input logic [31:0] res, input logic of, input logic uf,
                              input logic dz, input int lat);
    ref_t r;
    r.res = res; r.of = of; r.uf = uf; r.dz = dz; r.lat = lat;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    ref_t        r;
    logic [31:0] x, y;
    int          ndone, lat_seen, d;
    logic [31:0] res_seen;

    vecs.push_back('{32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 27)});
    vecs.push_back('{32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 0, 0, 0, 27)});
    vecs.push_back('{32'hBF800000, 32'h40400000, mk(32'hBEAAAAAA, 0, 0, 0, 27)});
    vecs.push_back('{32'h7F000000, 32'h00800000, mk(32'h7F800000, 1, 0, 0, 27)});
    vecs.push_back('{32'h7F000000, 32'h80800000, mk(32'hFF800000, 1, 0, 0, 27)});
    vecs.push_back('{32'h00800000, 32'h7F000000, mk(32'h00000000, 0, 1, 0, 27)});
    vecs.push_back('{32'h3F800000, 32'h00000000, mk(32'h7F800000, 0, 0, 1, 2)});
    vecs.push_back('{32'h00000000, 32'h00000000, mk(32'h7FC00000, 0, 0, 0, 2)});
    vecs.push_back('{32'h7F800000, 32'h7F800000, mk(32'h7FC00000, 0, 0, 0, 2)});
    vecs.push_back('{32'h40000000, 32'h7F800000, mk(32'h00000000, 0, 0, 0, 2)});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, mk(32'h7FC00000, 0, 0, 0, 2)});
    vecs.push_back('{32'hFF800000, 32'h40000000, mk(32'hFF800000, 0, 0, 0, 2)});
    vecs.push_back('{32'h80000000, 32'h3F800000, mk(32'h80000000, 0, 0, 0, 2)});
    vecs.push_back('{32'h00000001, 32'h3F800000, mk(32'h00000000, 0, 0, 0, 2)});
    vecs.push_back('{32'h3F800000, 32'h00400000, mk(32'h7F800000, 0, 0, 1, 2)});
    vecs.push_back('{32'h3F800000, 32'h3F800000, mk(32'h3F800000, 0, 0, 0, 27)});
    vecs.push_back('{32'h7F000000, 32'h3F000000, mk(32'h7F800000, 1, 0, 0, 27)});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, mk(32'h7F7FFFFF, 0, 0, 0, 27)});
    vecs.push_back('{32'h00800000, 32'h3F800000, mk(32'h00800000, 0, 0, 0, 27)});
    vecs.push_back('{32'h00800000, 32'h3F800001, mk(32'h00000000, 0, 1, 0, 27)});

    #2;
    check("reset_state", 64'({result, done, busy, overflow, underflow, div_by_zero}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: begin
          x[30:23] = 8'($urandom_range(100, 154));
          y[30:23] = 8'($urandom_range(100, 154));
        end
        2: begin
          x[30:23] = 8'($urandom_range(0, 1) * 255);
          if ($urandom_range(0, 1) == 1) x[22:0] = '0;
        end
        default: begin
          x[30:23] = 8'($urandom_range(230, 254));
          y[30:23] = 8'($urandom_range(1, 40));
          if ($urandom_range(0, 1) == 1) begin
            x[30:23] = 8'($urandom_range(1, 40));
            y[30:23] = 8'($urandom_range(230, 254));
          end
        end
      endcase
      run_op(x, y, ref_div(x, y), $sformatf("rnd%0d", i));
    end

    // start pulsed mid-divide must be ignored
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat_seen = 0; res_seen = '0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        lat_seen = i;
        res_seen = result;
      end
    end
    check("ignore_start/done_count", 64'(ndone), 64'd1);
    check("ignore_start/latency", 64'(lat_seen), 64'd27);
    check("ignore_start/result", 64'(res_seen), 64'h40400000);
    exp_prev = 32'h40400000;

    // asynchronous reset mid-operation
    run_op(32'h7F000000, 32'h00800000, mk(32'h7F800000, 1, 0, 0, 27), "pre_reset");
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({result, done, busy, overflow, underflow, div_by_zero}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_hold_no_done", 64'({done, busy}), 64'd0);
    rst_n = 1'b1;
    exp_prev = '0;
    run_op(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 27), "after_reset");

    // back-to-back with start held high; second operands appear after first accept
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h40400000;
    d = 0;
    while (!done && d < 60) begin
      @(posedge clk); #1;
      d++;
    end
    check("b2b/first_latency", 64'(d), 64'd27);
    check("b2b/first_result", 64'(result), 64'h40400000);
    d = 0;
    @(posedge clk); #1;
    d++;
    while (!done && d < 60) begin
      @(posedge clk); #1;
      d++;
    end
    start = 1'b0;
    check("b2b/second_spacing", 64'(d), 64'd29);
    check("b2b/second_result", 64'(result), 64'h3EAAAAAA);
    @(posedge clk); #1;
    check("b2b/idle_after", 64'({done, busy}), 64'd0);
    exp_prev = 32'h3EAAAAAA;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1);
  end

endmodule
